// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word array with a 2-entry store buffer.
// Loads return the full aligned word one cycle after acceptance.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic [31:0] rd_addr,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic [1:0]  size,
   output logic        busy,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [31:0]   data;
      logic [3:0]    strb;
   } entry_t;

   logic [31:0]   mem [DEPTH_WORDS];
   entry_t        sb [2];
   logic [1:0]    count;
   logic [1:0]    count_next;
   logic [1:0]    slot;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          raw_hit;
   logic          rd_ok;
   logic          wr_ok;
   logic          rd_fire;
   logic          wr_fire;
   logic          drain;
   logic          drop;
   logic [31:0]   new_data;
   logic [3:0]    new_strb;
   logic          unused_bits;

   function automatic logic aligned(input logic [1:0] sz, input logic [1:0] lo);
      logic ok;
      case (sz)
         2'b00:   ok = 1'b1;
         2'b01:   ok = (lo[0] == 1'b0);
         2'b10:   ok = (lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign rd_idx      = rd_addr[AW+1:2];
   assign wr_idx      = wr_addr[AW+1:2];
   assign unused_bits = ^{rd_addr[31:AW+2], wr_addr[31:AW+2]};

   assign rd_ok = aligned(size, rd_addr[1:0]);
   assign wr_ok = aligned(size, wr_addr[1:0]);

   // A load may not overtake a buffered store to the same word.
   assign raw_hit = ((count != 2'd0) && (sb[0].idx == rd_idx)) ||
                    ((count == 2'd2) && (sb[1].idx == rd_idx));

   assign busy    = (rd_en && raw_hit) || (wr_en && (count == 2'd2));
   assign rd_fire = rd_en && !busy && rd_ok;
   assign wr_fire = wr_en && !busy && wr_ok;
   assign drop    = (rd_en && !busy && !rd_ok) || (wr_en && !busy && !wr_ok);
   assign drain   = !rd_fire && (count != 2'd0);

   assign count_next = count + {1'b0, wr_fire} - {1'b0, drain};
   assign slot       = count - {1'b0, drain};

   always_comb begin
      new_data = wr_data;
      new_strb = 4'b1111;
      case (size)
         2'b00: begin
            new_data = {4{wr_data[7:0]}};
            new_strb = 4'b0001 << wr_addr[1:0];
         end
         2'b01: begin
            new_data = {2{wr_data[15:0]}};
            new_strb = wr_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            new_data = wr_data;
            new_strb = 4'b1111;
         end
      endcase
   end

   // Drain shifts the FIFO first; a same-cycle push lands in the freed slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
      end else begin
         count <= count_next;
         if (drain) begin
            sb[0] <= sb[1];
         end
         if (wr_fire) begin
            if (slot == 2'd0) begin
               sb[0] <= '{idx: wr_idx, data: new_data, strb: new_strb};
            end else begin
               sb[1] <= '{idx: wr_idx, data: new_data, strb: new_strb};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && drain) begin
         for (int b = 0; b < 4; b++) begin
            if (sb[0].strb[b]) begin
               mem[sb[0].idx][8*b +: 8] <= sb[0].data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= 32'd0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         err      <= drop;
         if (rd_fire) begin
            rd_data <= mem[rd_idx];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: reference memory + store-buffer model,
// with load responses scoreboarded in a queue.
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] rd_addr = '0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [1:0]  size = 2'b10;
   logic        busy;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        err;

   typedef struct {
      int         idx;
      logic [31:0] data;
      logic [3:0]  strb;
   } ent_t;

   int          total = 0;
   int          bad = 0;
   logic [31:0] mem_m [DEPTH];
   ent_t        sb_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] last_data = '0;
   logic        exp_busy;
   logic        last_busy;
   int          busy_seen;

   dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .size(size),
      .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic aligned_m(input logic [1:0] sz, input logic [31:0] a);
      case (sz)
         2'b00:   return 1'b1;
         2'b01:   return a[0] == 1'b0;
         2'b10:   return a[1:0] == 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] pat(input int i);
      return 32'h1000_0000 + i * 32'h0001_0101;
   endfunction

   // One clock of stimulus: model predicts busy/err/response, DUT is checked after the edge.
   task automatic applyStimulus(input logic r, input logic [31:0] ra, input logic w,
                                input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] sz);
      int   ri;
      logic raw, rf, wf, exp_err;
      ent_t e;
      @(negedge clk);
      rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_data = wd; size = sz;
      #1;
      ri  = int'(ra[AW+1:2]);
      raw = 1'b0;
      foreach (sb_q[i]) if (sb_q[i].idx == ri) raw = 1'b1;
      exp_busy  = (r && raw) || (w && sb_q.size() == 2);
      last_busy = busy;
      checkOutput("busy", {31'b0, busy}, {31'b0, exp_busy});
      rf      = r && !exp_busy && aligned_m(sz, ra);
      wf      = w && !exp_busy && aligned_m(sz, wa);
      exp_err = (r && !exp_busy && !aligned_m(sz, ra)) || (w && !exp_busy && !aligned_m(sz, wa));
      if (rf) exp_q.push_back(mem_m[ri]);
      if (!rf && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         for (int b = 0; b < 4; b++)
            if (e.strb[b]) mem_m[e.idx][8*b +: 8] = e.data[8*b +: 8];
      end
      if (wf) begin
         e.idx = int'(wa[AW+1:2]);
         case (sz)
            2'b00:   begin e.data = {4{wd[7:0]}};  e.strb = 4'b0001 << wa[1:0]; end
            2'b01:   begin e.data = {2{wd[15:0]}}; e.strb = wa[1] ? 4'b1100 : 4'b0011; end
            default: begin e.data = wd;            e.strb = 4'b1111; end
         endcase
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      checkOutput("rd_valid", {31'b0, rd_valid}, {31'b0, rf});
      checkOutput("err", {31'b0, err}, {31'b0, exp_err});
      if (rd_valid && exp_q.size() > 0) last_data = exp_q.pop_front();
      checkOutput("rd_data", rd_data, last_data);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10);
   endtask

   task automatic held(input logic r, input logic [31:0] ra, input logic w,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] sz);
      busy_seen = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(r, ra, w, wa, wd, sz);
         if (last_busy) busy_seen++;
         if (!exp_busy) break;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      checkOutput("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      checkOutput("rst_rd_data", rd_data, 32'd0);
      checkOutput("rst_err", {31'b0, err}, 32'd0);
      sb_q.delete();
      exp_q.delete();
      last_data = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      do_reset(2);

      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 1'b1, i * 4, pat(i), 2'b10);
      idle(2);

      // Word store then load after idling.
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 32'hDEADBEEF, 2'b10);
      idle(2);
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_word_load", rd_data, 32'hDEADBEEF);

      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 2'b10);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h41, 32'h000000AA, 2'b00);
      idle(2);
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_byte_merge", rd_data, 32'h0000AA00);

      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 2'b10);
      idle(2);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h42, 32'h00001234, 2'b01);
      held(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_raw_busy_cycles", busy_seen, 32'd1);
      checkOutput("s_raw_data", rd_data, 32'h12340000);

      // Load stream on an unrelated word keeps the buffer from draining.
      applyStimulus(1'b1, 32'h80, 1'b1, 32'h100, 32'h11111111, 2'b10);
      applyStimulus(1'b1, 32'h80, 1'b1, 32'h104, 32'h22222222, 2'b10);
      held(1'b1, 32'h80, 1'b1, 32'h100, 32'h33333333, 2'b10);
      checkOutput("s_full_busy", busy_seen, 32'd1);
      idle(3);
      applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_order_a", rd_data, 32'h33333333);
      applyStimulus(1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_order_b", rd_data, 32'h22222222);

      applyStimulus(1'b1, 32'h42, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_misaligned_err", {31'b0, err}, 32'd1);
      checkOutput("s_misaligned_valid", {31'b0, rd_valid}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h43, 32'hFFFF, 2'b01);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 32'hFFFFFFFF, 2'b11);
      idle(2);
      applyStimulus(1'b1, 32'h140, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_wrap_unchanged", rd_data, 32'h12340000);

      applyStimulus(1'b1, 32'h60, 1'b1, 32'h60, 32'hCAFEF00D, 2'b10);
      checkOutput("s_load_first", rd_data, pat(24));
      idle(1);
      applyStimulus(1'b1, 32'h60, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_store_after", rd_data, 32'hCAFEF00D);

      applyStimulus(1'b1, 32'h20, 1'b1, 32'h30, 32'hAAAA5555, 2'b10);
      applyStimulus(1'b1, 32'h20, 1'b1, 32'h34, 32'h5555AAAA, 2'b10);
      do_reset(1);
      applyStimulus(1'b1, 32'h30, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_rst_discard_a", rd_data, pat(12));
      applyStimulus(1'b1, 32'h34, 1'b0, 32'h0, 32'h0, 2'b10);
      checkOutput("s_rst_discard_b", rd_data, pat(13));

      for (int k = 0; k < 400; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), {$urandom, 8'h0} | 32'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), {$urandom, 8'h0} | 32'($urandom_range(0, 31)),
                       $urandom, 2'($urandom_range(0, 3)));
      end
      idle(4);
      checkOutput("sb_leftover", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
